// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//
// Purpose:
//   Load/store unit that sits directly after the ALU. It takes the ALU result
//   as the effective address and rs2 as the store data. Each request becomes
//   a single byte, halfword or word access on a single-port data-memory
//   handshake. The unit then returns a registered one-cycle response to
//   writeback. That response carries sign/zero-extended load data, zero for
//   a store, or the faulting address when the access is misaligned or
//   illegal.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   EX presents a memory operation
//   req_ready   LSU can accept a request (high only when idle)
//   req_we      1 = store, 0 = load
//   req_funct3  000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    effective address
//   req_wdata   store data (rs2)
//   mem_req     memory access request, held until mem_ready
//   mem_we      memory write enable
//   mem_addr    word-aligned memory address
//   mem_wstrb   byte write strobes (zero for loads)
//   mem_wdata   lane-aligned write data (zero for loads)
//   mem_ready   memory accepts the current request
//   mem_rvalid  read data valid
//   mem_rdata   read word
//   rsp_valid   one-cycle response pulse
//   rsp_err     misaligned or illegal access
//   rsp_rdata   extended load data / 0 for stores / faulting address on error
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DWIDTH-1:0] rsp_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              req_bad;
  logic [3:0]        st_strb;
  logic [DWIDTH-1:0] st_data;
  logic [DWIDTH-1:0] ld_shifted;
  logic [DWIDTH-1:0] ld_data;

  assign req_ready = (state_q == S_IDLE);

  // Classify the incoming request: illegal encodings, stores with the
  // unsigned bit set, and halfword/word accesses off their natural alignment
  // all fault without touching memory.
  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_bad = 1'b0;
      3'b001, 3'b101: req_bad = req_addr[0];
      3'b010:         req_bad = (req_addr[1:0] != 2'b00);
      default:        req_bad = 1'b1;
    endcase
    if (req_we && req_funct3[2]) begin
      req_bad = 1'b1;
    end
  end

  // Store lane formatting: replicate the data across the word and enable
  // only the lanes that the access touches.
  always_comb begin
    st_strb = 4'b1111;
    st_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend it.
  always_comb begin
    ld_shifted = mem_rdata >> {off_q, 3'b000};
    ld_data    = mem_rdata;
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b100:  ld_data = {24'd0, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b101:  ld_data = {16'd0, ld_shifted[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state logic. Every output is registered, so each transition also
  // computes the output values that the next cycle presents.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (req_bad) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = DWIDTH'(req_addr);
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[AWIDTH-1:2], 2'b00};
            mem_wstrb_d = req_we ? st_strb : 4'b0000;
            mem_wdata_d = req_we ? st_data : '0;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (we_q) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ld_data;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
//
// Purpose:
//   Self-checking bench for lsu_mem_stage. Stimulus tasks drive directed
//   transactions and push the expected response, including the cycle it must
//   appear in, onto a scoreboard queue. A monitor pops an entry for every
//   rsp_valid pulse and compares it against that entry.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   passCnt  = 0;
  int   totalCnt = 0;
  int   cyc      = 0;
  int   rspSeen  = 0;

  lsu_mem_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCnt++;
    if (actual === expected) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry,
  // including the cycle in which it appears.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rspSeen++;
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("[TB] FAIL unexpected_rsp: actual=rsp_valid@%0d required=none, rdata=0x%08h",
                 cyc, rsp_rdata);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic pushExp(input logic err, input logic [31:0] rdata, input int at);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    e.cyc   = at;
    expQ.push_back(e);
  endtask

  task automatic waitIdle();
    bit seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput("wait_idle_timeout", 32'(req_ready), 32'd1);
  endtask

  // One complete transaction: memory stalls for readyDelay cycles, and load
  // data arrives in the cycle after mem_ready.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int readyDelay, input logic [31:0] rdata,
                               input logic expErr, input logic [31:0] expRdata,
                               input logic [3:0] expStrb, input logic [31:0] expWdata);
    int c;
    @(posedge clk); #1;
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    c = cyc;
    if (expErr)  pushExp(1'b1, expRdata, c + 1);
    else if (we) pushExp(1'b0, expRdata, c + 2 + readyDelay);
    else         pushExp(1'b0, expRdata, c + 3 + readyDelay);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (expErr) begin
      @(negedge clk);
      checkOutput("err_no_mem_req", 32'(mem_req), 32'd0);
    end else begin
      for (int i = 0; i <= readyDelay; i++) begin
        if (i == readyDelay) mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("mem_req_held", 32'(mem_req), 32'd1);
        checkOutput("mem_we", 32'(mem_we), 32'(we));
        checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
        checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(expStrb));
        checkOutput("mem_wdata", mem_wdata, expWdata);
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      if (!we) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        checkOutput("mem_req_dropped", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
      end
    end
    waitIdle();
  endtask

  initial begin
    int c;
    int seenBefore;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    #2;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // LW, LB, LBU, LH
    applyStimulus(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'b0000, 32'd0);
    applyStimulus(1'b0, 3'b000, 32'h103, 32'd0, 0, 32'h80FF1234, 1'b0, 32'hFFFFFF80, 4'b0000, 32'd0);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'd0, 0, 32'h80FF1234, 1'b0, 32'h00000080, 4'b0000, 32'd0);
    applyStimulus(1'b0, 3'b001, 32'h102, 32'd0, 1, 32'h80FF1234, 1'b0, 32'hFFFF80FF, 4'b0000, 32'd0);
    // SH with three stall cycles, SW with one
    applyStimulus(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'd0, 1'b0, 32'd0, 4'b1100, 32'hABCDABCD);
    applyStimulus(1'b1, 3'b010, 32'h010, 32'h11223344, 1, 32'd0, 1'b0, 32'd0, 4'b1111, 32'h11223344);
    // Faults: misaligned LW, funct3=011, store with unsigned bit set
    applyStimulus(1'b0, 3'b010, 32'h102, 32'd0, 0, 32'd0, 1'b1, 32'h00000102, 4'b0000, 32'd0);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'd0, 0, 32'd0, 1'b1, 32'h00000100, 4'b0000, 32'd0);
    applyStimulus(1'b1, 3'b100, 32'h104, 32'h55, 0, 32'd0, 1'b1, 32'h00000104, 4'b0000, 32'd0);

    // Back-to-back: SB, then LHU held by EX while the LSU is busy
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h301; req_wdata = 32'h0000005A;
    c = cyc;
    pushExp(1'b0, 32'd0, c + 2);
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'b101; req_addr = 32'h302; req_wdata = 32'd0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("b2b_busy_ready_req", 32'(req_ready), 32'd0);
    checkOutput("b2b_sb_wstrb", 32'(mem_wstrb), 32'h2);
    checkOutput("b2b_sb_wdata", mem_wdata, 32'h5A5A5A5A);
    checkOutput("b2b_sb_addr", mem_addr, 32'h300);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_busy_ready_resp", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("b2b_ready_after_resp", 32'(req_ready), 32'd1);
    pushExp(1'b0, 32'h0000FEDC, cyc + 3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("b2b_lhu_addr", mem_addr, 32'h300);
    checkOutput("b2b_lhu_wstrb", 32'(mem_wstrb), 32'h0);
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFEDC0000;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    waitIdle();

    // Reset while waiting for load data; a late rvalid must be ignored
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checkOutput("wait_busy", 32'(req_ready), 32'd0);
    seenBefore = rspSeen;
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rstw_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("late_rvalid_no_rsp", 32'(rspSeen), 32'(seenBefore));

    // Reset while a store request is outstanding: mem_req drops at once
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h400; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstr_mem_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstr_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rstr_mem_addr", mem_addr, 32'd0);
    checkOutput("rstr_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
